// File: rtl/key_debounce_fsm.sv
// Debounces the keypad scanner's key_down/key_code pair into one strobe per press
// and keeps a two-deep history of accepted key codes.
module key_debounce_fsm #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_down,
  input  logic [3:0] key_code,
  output logic       key_strobe,
  output logic [3:0] new_digit,
  output logic [3:0] prev_digit,
  output logic       busy
);

  typedef enum logic [1:0] {
    Idle     = 2'd0,
    PressChk = 2'd1,
    Held     = 2'd2,
    RelChk   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       cap_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= Idle;
      cnt        <= '0;
      cap_code   <= 4'h0;
      key_strobe <= 1'b0;
      new_digit  <= 4'h0;
      prev_digit <= 4'h0;
      busy       <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      unique case (state)
        Idle: begin
          if (key_down) begin
            state    <= PressChk;
            cap_code <= key_code;
            cnt      <= CntOne;
            busy     <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        PressChk: begin
          if (!key_down) begin
            state <= Idle;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (key_code != cap_code) begin
            // A mid-press code glitch restarts the window on the new code
            cap_code <= key_code;
            cnt      <= CntOne;
          end else if (cnt == CntMax) begin
            state      <= Held;
            key_strobe <= 1'b1;
            prev_digit <= new_digit;
            new_digit  <= cap_code;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        Held: begin
          if (!key_down) begin
            state <= RelChk;
            cnt   <= CntOne;
          end
        end
        RelChk: begin
          if (key_down) begin
            state <= Held;
            cnt   <= '0;
          end else if (cnt == CntMax) begin
            state <= Idle;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= Idle;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce_fsm.sv
// Directed bench for key_debounce_fsm with DEBOUNCE_CYCLES=4.
module tb_key_debounce_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_down;
  logic [3:0] key_code;
  logic       key_strobe;
  logic [3:0] new_digit;
  logic [3:0] prev_digit;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  key_debounce_fsm #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_down   (key_down),
    .key_code   (key_code),
    .key_strobe (key_strobe),
    .new_digit  (new_digit),
    .prev_digit (prev_digit),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs, take one clock edge, then settle 1ns past it.
  task automatic tick(input logic kd, input logic [3:0] code);
    key_down = kd;
    key_code = code;
    @(posedge clk);
    #1;
    if (key_strobe === 1'b1) strobes++;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int s0;

  initial begin
    rst      = 1'b1;
    key_down = 1'b0;
    key_code = 4'h0;
    #1;
    chk("rst_strobe", {7'b0, key_strobe}, 8'h0);
    chk("rst_new",    {4'b0, new_digit},  8'h0);
    chk("rst_prev",   {4'b0, prev_digit}, 8'h0);
    chk("rst_busy",   {7'b0, busy},       8'h0);
    rst = 1'b0;
    tick(1'b0, 4'h0);

    // Clean press of 0x7
    s0 = strobes;
    tick(1'b1, 4'h7);
    chk("clean_busy_e0", {7'b0, busy}, 8'h1);
    tick(1'b1, 4'h7);
    tick(1'b1, 4'h7);
    chk("clean_nostrobe_e2", {7'b0, key_strobe}, 8'h0);
    tick(1'b1, 4'h7);
    chk("clean_strobe_e3", {7'b0, key_strobe}, 8'h1);
    chk("clean_new", {4'b0, new_digit}, 8'h07);
    chk("clean_prev", {4'b0, prev_digit}, 8'h00);
    for (int i = 0; i < 6; i++) tick(1'b1, 4'h7);
    chk("clean_strobe_off", {7'b0, key_strobe}, 8'h0);
    for (int i = 0; i < 3; i++) tick(1'b0, 4'h7);
    chk("clean_busy_r2", {7'b0, busy}, 8'h1);
    tick(1'b0, 4'h7);
    chk("clean_busy_r3", {7'b0, busy}, 8'h0);
    tick(1'b0, 4'h7);
    tick(1'b0, 4'h7);
    chk("clean_count", 8'(strobes - s0), 8'd1);

    // Bounce rejection
    pulse_reset();
    s0 = strobes;
    tick(1'b1, 4'h3);
    tick(1'b0, 4'h3);
    chk("bounce_idle1", {6'b0, dut.state}, 8'd0);
    tick(1'b1, 4'h3);
    tick(1'b1, 4'h3);
    chk("bounce_cnt2", {6'b0, dut.state}, 8'd1);
    tick(1'b0, 4'h3);
    tick(1'b0, 4'h3);
    tick(1'b0, 4'h3);
    chk("bounce_count", 8'(strobes - s0), 8'd0);
    chk("bounce_new", {4'b0, new_digit}, 8'h00);
    chk("bounce_busy", {7'b0, busy}, 8'h0);

    // Code change during PRESS_CHK
    s0 = strobes;
    tick(1'b1, 4'h5);
    tick(1'b1, 4'h5);
    tick(1'b1, 4'hA);
    tick(1'b1, 4'hA);
    tick(1'b1, 4'hA);
    chk("chg_nostrobe_3", {7'b0, key_strobe}, 8'h0);
    tick(1'b1, 4'hA);
    chk("chg_strobe_4", {7'b0, key_strobe}, 8'h1);
    chk("chg_new", {4'b0, new_digit}, 8'h0A);
    chk("chg_count", 8'(strobes - s0), 8'd1);
    for (int i = 0; i < 4; i++) tick(1'b0, 4'h0);

    // Two-digit history
    s0 = strobes;
    for (int i = 0; i < 4; i++) tick(1'b1, 4'h1);
    chk("hist_new1", {4'b0, new_digit}, 8'h01);
    chk("hist_prev1", {4'b0, prev_digit}, 8'h0A);
    for (int i = 0; i < 4; i++) tick(1'b0, 4'h1);
    for (int i = 0; i < 4; i++) tick(1'b1, 4'hC);
    chk("hist_new2", {4'b0, new_digit}, 8'h0C);
    chk("hist_prev2", {4'b0, prev_digit}, 8'h01);
    chk("hist_count", 8'(strobes - s0), 8'd2);
    // Code changes while held are ignored
    tick(1'b1, 4'h2);
    chk("held_ignore", {4'b0, new_digit}, 8'h0C);
    for (int i = 0; i < 4; i++) tick(1'b0, 4'h0);

    // Release bounce after accepting 0x9
    for (int i = 0; i < 4; i++) tick(1'b1, 4'h9);
    chk("relb_new", {4'b0, new_digit}, 8'h09);
    chk("relb_prev", {4'b0, prev_digit}, 8'h0C);
    s0 = strobes;
    tick(1'b0, 4'h9);
    chk("relb_s0", {6'b0, dut.state}, 8'd3);
    tick(1'b0, 4'h9);
    tick(1'b1, 4'h9);
    chk("relb_s2", {6'b0, dut.state}, 8'd2);
    tick(1'b1, 4'h9);
    tick(1'b0, 4'h9);
    chk("relb_s4", {6'b0, dut.state}, 8'd3);
    tick(1'b0, 4'h9);
    tick(1'b0, 4'h9);
    chk("relb_s6", {6'b0, dut.state}, 8'd3);
    tick(1'b0, 4'h9);
    chk("relb_s7", {6'b0, dut.state}, 8'd0);
    chk("relb_count", 8'(strobes - s0), 8'd0);

    // Asynchronous reset mid-press
    for (int i = 0; i < 4; i++) tick(1'b1, 4'h4);
    chk("arst_pre_new", {4'b0, new_digit}, 8'h04);
    for (int i = 0; i < 4; i++) tick(1'b0, 4'h0);
    s0 = strobes;
    tick(1'b1, 4'h5);
    tick(1'b1, 4'h5);
    chk("arst_cnt2", {6'b0, dut.cnt}, 8'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_new", {4'b0, new_digit}, 8'h00);
    chk("arst_prev", {4'b0, prev_digit}, 8'h00);
    chk("arst_busy", {7'b0, busy}, 8'h0);
    chk("arst_strobe", {7'b0, key_strobe}, 8'h0);
    key_down = 1'b0;
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b0, 4'h5);
    chk("arst_count", 8'(strobes - s0), 8'd0);
    chk("arst_idle", {7'b0, busy}, 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_debounce_fsm.md
Name: key_debounce_fsm

Overview:
- Sits directly downstream of the keypad scanner FSM.
- Consumes the scanner's raw key code and key-down indication, and rejects contact bounce and mid-press code glitches.
- Emits exactly one registered strobe per physical press, and keeps a two-digit history (newest and previous).
- The history feeds the seven-segment display mux; prev_digit also feeds back to the scanner's previous-number input.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable samples required to accept a press and to accept a release (legal range 2..2^20).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of the internal stability counter.

Ports:
- clk  input  1  system clock, same clock as the scanner FSM
- rst  input  1  reset, asynchronous, active-high
- key_down  input  1  high while the scanner reports any row active in the driven column
- key_code  input  4  hex code of the key currently reported by the scanner (0x0-0xF)
- key_strobe  output  1  one-cycle pulse when a debounced press is accepted
- new_digit  output  4  most recently accepted key code
- prev_digit  output  4  key code accepted before new_digit
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: one clock, rst asynchronous active-high.
  - Asserting rst forces state=IDLE, cnt=0, cap_code=0, key_strobe=0, new_digit=0, prev_digit=0, busy=0, immediately and independent of clk.
  - Reset mid-press discards the press in progress; no strobe is emitted.
- All outputs are registered; there are no combinational paths from input to output.
- States: IDLE, PRESS_CHK, HELD, REL_CHK.
- IDLE:
  - Sample key_down=1 -> PRESS_CHK, cap_code<=key_code, cnt<=1.
  - Otherwise stay in IDLE.
- PRESS_CHK:
  - key_down=0 -> IDLE, cnt<=0, no strobe (bounce rejected).
  - key_down=1 and key_code!=cap_code -> stay in PRESS_CHK, cap_code<=key_code, cnt<=1 (restart on the new code).
  - key_down=1, code equal, cnt==DEBOUNCE_CYCLES-1 -> HELD, key_strobe<=1, prev_digit<=new_digit, new_digit<=cap_code.
  - Otherwise cnt<=cnt+1.
- HELD:
  - key_down=1 -> stay in HELD; no further strobes, and code changes are ignored.
  - key_down=0 -> REL_CHK, cnt<=1.
- REL_CHK:
  - key_down=1 -> HELD, cnt<=0. The release was bounce; no new strobe.
  - key_down=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt<=0.
  - Otherwise cnt<=cnt+1.
- Latency: a press stable from clock edge 0 produces key_strobe high for exactly the cycle following edge DEBOUNCE_CYCLES-1. new_digit and prev_digit update on that same edge.
- key_strobe defaults to 0 every cycle. It is never high for two consecutive cycles.
- The counter never exceeds DEBOUNCE_CYCLES-1 and does not wrap.
- Repeated identical keys shift normally: prev_digit becomes equal to new_digit.
- A new press is accepted only after a full release window completes (REL_CHK -> IDLE).
- Illegal or unreachable state encodings recover to IDLE on the next edge, with outputs held.

Test Plan:
- Clean press, DEBOUNCE_CYCLES=4: rst pulse, then key_down=1, key_code=0x7 held for 10 cycles, then released for 6 cycles.
  - Required: exactly one key_strobe, high in the cycle after edge 3; new_digit=0x7, prev_digit=0x0.
  - busy returns to 0 four cycles after release.
- Bounce rejection: key_down toggles 1,0,1,1,0 with key_code=0x3, then stays 0.
  - Required: no key_strobe; new_digit remains 0x0; state returns to IDLE.
- Code change during PRESS_CHK: key_code=0x5 for 2 cycles, then 0xA held for 4 cycles, key_down=1 throughout.
  - Required: one strobe, new_digit=0xA, and the strobe occurs 4 samples after 0xA first appears.
- Two-digit history: accept 0x1, release fully, then accept 0xC.
  - Required: new_digit=0xC, prev_digit=0x1, and two strobes in total.
- Release bounce: after accepting 0x9, key_down sequence 0,0,1,1,0,0,0,0.
  - Required: no second strobe; state goes HELD -> REL_CHK -> HELD -> REL_CHK -> IDLE.
- Asynchronous reset mid-operation: assert rst between clock edges while in PRESS_CHK with cnt=2, after 0x4 was previously accepted.
  - Required: outputs go to 0 before the next edge; no strobe follows when rst deasserts with key_down=0.
